// File: rtl/pwm_timer_mc.sv
// Multi-channel PWM timer: NUM_CH outputs share one period counter, run for STOP
// PWM cycles, then hold o_timer_end for END_HOLD clocks (one-shot or continuous).
module pwm_timer_mc #(
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int CYC_W    = 8,
  parameter int ADDR_W   = 2,
  parameter int END_HOLD = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_mode,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [NUM_CH-1:0] i_pol,
  output logic [NUM_CH-1:0] o_pwm,
  output logic              o_timer_end,
  output logic              o_busy,
  output logic [CYC_W-1:0]  o_cycle_cnt
);

  localparam int HOLD_W = $clog2(END_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(END_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic [DATA_W-1:0] period_r, period_sh_r, cnt_r;
  logic [CYC_W-1:0]  stop_r, stop_sh_r, cyc_r, cyc_inc_s;
  logic [DATA_W-1:0] duty_r    [NUM_CH];
  logic [DATA_W-1:0] duty_sh_r [NUM_CH];
  logic [HOLD_W-1:0] hold_r;
  logic              wrap_s, load_s;
  logic [NUM_CH-1:0] cmp_s, pwm_s;

  assign o_cycle_cnt = cyc_r;

  // Register-bus writes; visible to the core one clock after the write strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      period_r <= {DATA_W{1'b0}};
      stop_r   <= {CYC_W{1'b0}};
      for (int k = 0; k < NUM_CH; k++) duty_r[k] <= {DATA_W{1'b0}};
    end else if (i_we) begin
      if (i_addr == ADDR_W'(0)) begin
        period_r <= i_wdata;
      end else if (i_addr == ADDR_W'(1)) begin
        stop_r <= i_wdata[CYC_W-1:0];
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (i_addr == ADDR_W'(k + 2)) duty_r[k] <= i_wdata;
        end
      end
    end
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    wrap_s    = (cnt_r == (period_sh_r - DATA_W'(1)));
    cyc_inc_s = cyc_r + CYC_W'(1);
    if (i_abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_start && (period_r != {DATA_W{1'b0}})) begin
            state_s = ST_RUN;
            load_s  = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (wrap_s && (stop_sh_r != {CYC_W{1'b0}}) && (cyc_inc_s == stop_sh_r)) state_s = ST_HOLD;
          else state_s = ST_RUN;
        end
        ST_HOLD: begin
          // A zero period at restart would never wrap, so fall back to IDLE instead.
          if (hold_r == HOLD_LAST) begin
            if (i_mode && (period_r != {DATA_W{1'b0}})) begin
              state_s = ST_RUN;
              load_s  = 1'b1;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_HOLD;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Channel compare; outputs idle at the inactive level outside RUN.
  always_comb begin
    cmp_s = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) cmp_s[k] = (cnt_r >= duty_sh_r[k]);
    if ((state_r == ST_RUN) && !i_abort) pwm_s = cmp_s ^ i_pol;
    else pwm_s = i_pol;
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Counters, shadows and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r       <= {DATA_W{1'b0}};
      cyc_r       <= {CYC_W{1'b0}};
      hold_r      <= {HOLD_W{1'b0}};
      period_sh_r <= {DATA_W{1'b0}};
      stop_sh_r   <= {CYC_W{1'b0}};
      for (int k = 0; k < NUM_CH; k++) duty_sh_r[k] <= {DATA_W{1'b0}};
      o_pwm       <= {NUM_CH{1'b0}};
      o_timer_end <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      if (i_abort) begin
        cnt_r  <= {DATA_W{1'b0}};
        cyc_r  <= {CYC_W{1'b0}};
        hold_r <= {HOLD_W{1'b0}};
      end else if (load_s) begin
        cnt_r       <= {DATA_W{1'b0}};
        cyc_r       <= {CYC_W{1'b0}};
        hold_r      <= {HOLD_W{1'b0}};
        period_sh_r <= period_r;
        stop_sh_r   <= stop_r;
        for (int k = 0; k < NUM_CH; k++) duty_sh_r[k] <= duty_r[k];
      end else if (state_r == ST_RUN) begin
        hold_r <= {HOLD_W{1'b0}};
        if (wrap_s) begin
          cnt_r <= {DATA_W{1'b0}};
          cyc_r <= cyc_inc_s;
          for (int k = 0; k < NUM_CH; k++) duty_sh_r[k] <= duty_r[k];
        end else begin
          cnt_r <= cnt_r + DATA_W'(1);
        end
      end else if (state_r == ST_HOLD) begin
        hold_r <= hold_r + HOLD_W'(1);
      end
      o_pwm       <= pwm_s;
      o_timer_end <= (state_s == ST_HOLD);
      o_busy      <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_pwm_timer_mc.sv
// Self-checking bench for pwm_timer_mc: randomized runs compared against an
// arithmetic timeline model (period index / phase derived from elapsed clocks).
module tb_pwm_timer_mc;

  localparam int END_HOLD = 10;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic        i_mode = 1'b0;
  logic        i_we = 1'b0;
  logic [1:0]  i_addr = 2'd0;
  logic [15:0] i_wdata = 16'd0;
  logic [1:0]  i_pol = 2'b00;
  logic [1:0]  o_pwm;
  logic        o_timer_end;
  logic        o_busy;
  logic [7:0]  o_cycle_cnt;

  int checks = 0;
  int failures = 0;

  pwm_timer_mc #(.DATA_W(16), .NUM_CH(2), .CYC_W(8), .ADDR_W(2), .END_HOLD(END_HOLD)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort), .i_mode(i_mode),
    .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_pol(i_pol),
    .o_pwm(o_pwm), .o_timer_end(o_timer_end), .o_busy(o_busy), .o_cycle_cnt(o_cycle_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
    @(negedge i_clk);
    i_we = 1'b1; i_addr = a; i_wdata = d;
    @(negedge i_clk);
    i_we = 1'b0;
  endtask

  task automatic test_reset();
    i_pol = 2'b11;
    #7;
    checks++;
    if ({o_pwm, o_timer_end, o_busy, o_cycle_cnt} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=000", {o_pwm, o_timer_end, o_busy, o_cycle_cnt});
    end
    @(negedge i_clk); i_rst = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (o_pwm !== 2'b11 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset pwm=%b busy=%b want pwm=11 busy=0", o_pwm, o_busy);
    end
  endtask

  // One-shot run; optional single duty write landing at edge w. PERIOD is rewritten at
  // the start edge to check the shadow takes the pre-write value.
  task automatic test_oneshot(input int p, input int s, input int d0, input int d1,
                              input logic [1:0] pol, input bit wr_en, input int wr_ch,
                              input int wr_val, input int w);
    int run_len, tot, j, pi, c, dk;
    logic [1:0] pwm_e;
    logic busy_e, end_e;
    i_mode = 1'b0; i_pol = pol;
    write_reg(2'd0, 16'(p)); write_reg(2'd1, 16'(s));
    write_reg(2'd2, 16'(d0)); write_reg(2'd3, 16'(d1));
    run_len = p * s; tot = run_len + END_HOLD;
    for (int i = 0; i <= tot; i++) begin
      @(negedge i_clk);
      i_start = (i == 0); i_we = 1'b0;
      if (i == 0) begin
        i_we = 1'b1; i_addr = 2'd0; i_wdata = 16'(p + 3);
      end else if (wr_en && i == w) begin
        i_we = 1'b1; i_addr = 2'(2 + wr_ch); i_wdata = 16'(wr_val);
      end
      @(posedge i_clk); #1;
      busy_e = (i < tot);
      end_e = (i >= run_len) && (i < tot);
      pwm_e = pol;
      if (i >= 1 && i <= run_len) begin
        j = i - 1; pi = j / p; c = j % p;
        for (int k = 0; k < 2; k++) begin
          dk = (k == 0) ? d0 : d1;
          if (wr_en && wr_ch == k && pi >= 1 && w < pi * p) dk = wr_val;
          pwm_e[k] = (c >= dk) ^ pol[k];
        end
      end
      checks++;
      if (o_busy !== busy_e) begin
        failures++;
        $display("FAIL oneshot_busy i=%0d got=%b want=%b", i, o_busy, busy_e);
      end
      checks++;
      if (o_timer_end !== end_e) begin
        failures++;
        $display("FAIL oneshot_end i=%0d got=%b want=%b", i, o_timer_end, end_e);
      end
      checks++;
      if (o_pwm !== pwm_e) begin
        failures++;
        $display("FAIL oneshot_pwm i=%0d P=%0d got=%b want=%b", i, p, o_pwm, pwm_e);
      end
      if (i < tot) begin
        checks++;
        if (o_cycle_cnt !== 8'((i < run_len) ? i / p : s)) begin
          failures++;
          $display("FAIL oneshot_cyc i=%0d got=%0d want=%0d", i, o_cycle_cnt, (i < run_len) ? i / p : s);
        end
      end
    end
    @(negedge i_clk); i_start = 1'b0; i_we = 1'b0;
  endtask

  task automatic test_continuous();
    int p, s, d0, d1, run_len, len, r;
    logic [1:0] pol, pwm_e;
    p = 5; s = 2; d0 = 2; d1 = 4; pol = 2'($urandom_range(0, 3));
    i_pol = pol; i_mode = 1'b1;
    write_reg(2'd0, 16'(p)); write_reg(2'd1, 16'(s));
    write_reg(2'd2, 16'(d0)); write_reg(2'd3, 16'(d1));
    run_len = p * s; len = run_len + END_HOLD;
    for (int i = 0; i < 3 * len; i++) begin
      @(negedge i_clk); i_start = (i == 0);
      @(posedge i_clk); #1;
      r = i % len;
      pwm_e = pol;
      if (r >= 1 && r <= run_len) begin
        pwm_e[0] = (((r - 1) % p) >= d0) ^ pol[0];
        pwm_e[1] = (((r - 1) % p) >= d1) ^ pol[1];
      end
      checks++;
      if (o_busy !== 1'b1 || o_timer_end !== (r >= run_len)) begin
        failures++;
        $display("FAIL cont_flags i=%0d busy=%b end=%b want end=%b", i, o_busy, o_timer_end, r >= run_len);
      end
      checks++;
      if (o_cycle_cnt !== 8'((r < run_len) ? r / p : s)) begin
        failures++;
        $display("FAIL cont_cyc i=%0d got=%0d want=%0d", i, o_cycle_cnt, (r < run_len) ? r / p : s);
      end
      checks++;
      if (o_pwm !== pwm_e) begin
        failures++;
        $display("FAIL cont_pwm i=%0d got=%b want=%b", i, o_pwm, pwm_e);
      end
    end
    @(negedge i_clk); i_start = 1'b0; i_abort = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if ({o_busy, o_timer_end, o_cycle_cnt} !== 10'd0 || o_pwm !== pol) begin
      failures++;
      $display("FAIL cont_abort busy=%b end=%b cyc=%0d pwm=%b want 0/0/0/%b", o_busy, o_timer_end, o_cycle_cnt, o_pwm, pol);
    end
    @(negedge i_clk); i_abort = 1'b0; i_mode = 1'b0;
  endtask

  task automatic test_abort(input bit in_hold);
    int p, run_len, a;
    logic [1:0] pol;
    p = $urandom_range(3, 8); pol = 2'($urandom_range(0, 3));
    i_pol = pol; i_mode = 1'b0;
    write_reg(2'd0, 16'(p)); write_reg(2'd1, 16'd3);
    write_reg(2'd2, 16'($urandom_range(0, p))); write_reg(2'd3, 16'($urandom_range(0, p)));
    run_len = 3 * p;
    a = in_hold ? run_len + 3 : $urandom_range(p, run_len - 2);
    for (int i = 0; i <= a; i++) begin
      @(negedge i_clk); i_start = (i == 0);
      @(posedge i_clk); #1;
    end
    @(negedge i_clk); i_start = 1'b0; i_abort = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if ({o_busy, o_timer_end, o_cycle_cnt} !== 10'd0 || o_pwm !== pol) begin
      failures++;
      $display("FAIL abort_%s a=%0d busy=%b end=%b cyc=%0d pwm=%b want 0/0/0/%b",
               in_hold ? "hold" : "run", a, o_busy, o_timer_end, o_cycle_cnt, o_pwm, pol);
    end
    @(negedge i_clk); i_abort = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_stays_idle busy=%b want=0", o_busy);
    end
  endtask

  task automatic test_period_zero();
    write_reg(2'd0, 16'd0);
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      checks++;
      if (o_busy !== 1'b0 || o_pwm !== i_pol) begin
        failures++;
        $display("FAIL period_zero busy=%b pwm=%b want busy=0 pwm=%b", o_busy, o_pwm, i_pol);
      end
    end
  endtask

  task automatic test_reset_midrun();
    i_pol = 2'b01;
    write_reg(2'd0, 16'd6); write_reg(2'd1, 16'd0);
    write_reg(2'd2, 16'd2); write_reg(2'd3, 16'd3);
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    repeat (15) @(posedge i_clk);
    #3 i_rst = 1'b1;
    #1;
    checks++;
    if ({o_pwm, o_timer_end, o_busy, o_cycle_cnt} !== 12'd0) begin
      failures++;
      $display("FAIL reset_midrun got=%h want=000", {o_pwm, o_timer_end, o_busy, o_cycle_cnt});
    end
    @(negedge i_clk); i_rst = 1'b0;
  endtask

  initial begin
    int p, s;
    test_reset();
    test_oneshot(10, 3, 4, 7, 2'b00, 1'b0, 0, 0, 1);
    test_oneshot(10, 3, 4, 7, 2'b00, 1'b1, 0, 8, 5);
    test_oneshot(10, 3, 0, 12, 2'b10, 1'b0, 0, 0, 1);
    for (int n = 0; n < 8; n++) begin
      p = $urandom_range(1, 12); s = $urandom_range(1, 4);
      test_oneshot(p, s, $urandom_range(0, p + 2), $urandom_range(0, p + 2),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                   $urandom_range(0, p + 2), $urandom_range(1, p * s));
    end
    test_continuous();
    test_abort(1'b0);
    test_abort(1'b1);
    test_period_zero();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
